// File: rtl/shift_sequencer.sv
// Multi-pass sequencer around an 8-bit combinational barrel shifter.
// Each command runs as passes of up to MAX_STEP bits; overflow is sticky for the whole command.

module barrel_shifter (
    input  logic [7:0] a,
    input  logic [2:0] s,
    input  logic [2:0] opcode,
    output logic [7:0] y,
    output logic       overflow
);
    logic [3:0] s_p1;
    logic [3:0] s_inv;
    logic [7:0] lost_mask;
    logic [7:0] asl_mask;
    logic [7:0] asl_bits;

    assign s_p1      = {1'b0, s} + 4'd1;
    assign s_inv     = 4'd8 - {1'b0, s};
    assign lost_mask = ~(8'hFF >> s);
    // Arithmetic left keeps the sign only if the top s+1 bits all agree.
    assign asl_mask  = ~(8'hFF >> s_p1);
    assign asl_bits  = a & asl_mask;

    always_comb begin
        y        = a;
        overflow = 1'b0;
        case (opcode)
            3'b000: begin
                y        = a << s;
                overflow = (asl_bits != 8'h00) && (asl_bits != asl_mask);
            end
            3'b001: begin
                y        = a << s;
                overflow = |(a & lost_mask);
            end
            3'b010:  y = (a << s) | (a >> s_inv);
            3'b100:  y = $signed(a) >>> s;
            3'b101:  y = a >> s;
            3'b110:  y = (a >> s) | (a << s_inv);
            default: y = a;
        endcase
    end
endmodule

module shift_sequencer #(
    parameter int MAX_STEP = 7
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    input  logic [4:0] in_amt,
    input  logic [2:0] in_opcode,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_data,
    output logic       out_overflow,
    output logic       out_err,
    output logic       busy
);
    localparam logic [2:0] STEP_MAX = 3'(MAX_STEP);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] data_q;
    logic [2:0] op_q;
    logic [4:0] rem_q;
    logic       ovf_q;
    logic       err_q;

    logic       reserved;
    logic [4:0] eff_amt;
    logic [2:0] step;
    logic [4:0] rem_next;
    logic [7:0] shift_y;
    logic       shift_ovf;
    logic       accept;

    assign reserved = (in_opcode[1:0] == 2'b11);
    always_comb begin
        eff_amt = in_amt;
        if (reserved)
            eff_amt = 5'd0;
        else if (in_opcode[1])
            eff_amt = {2'b00, in_amt[2:0]};
    end

    assign step     = (rem_q > {2'b00, STEP_MAX}) ? STEP_MAX : rem_q[2:0];
    assign rem_next = rem_q - {2'b00, step};
    assign accept   = in_valid && in_ready;

    barrel_shifter u_shifter (
        .a        (data_q),
        .s        (step),
        .opcode   (op_q),
        .y        (shift_y),
        .overflow (shift_ovf)
    );

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid)
                    state_d = (eff_amt != 5'd0) ? SHIFT : DONE;
            end
            SHIFT: begin
                if (rem_next == 5'd0)
                    state_d = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            data_q  <= 8'h00;
            op_q    <= 3'b000;
            rem_q   <= 5'd0;
            ovf_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                data_q <= in_data;
                op_q   <= in_opcode;
                rem_q  <= eff_amt;
                ovf_q  <= 1'b0;
                err_q  <= reserved;
            end else if (state_q == SHIFT) begin
                data_q <= shift_y;
                rem_q  <= rem_next;
                ovf_q  <= ovf_q | shift_ovf;
            end
        end
    end

    assign out_data     = data_q;
    assign out_overflow = ovf_q;
    assign out_err      = err_q;
    assign busy         = (state_q != IDLE);
endmodule
